param_sync_fifo: RTL
====================

Name: param_sync_fifo

Overview:
- Parametrised single-clock FIFO: next generation of the team's 10x8 shifting FIFO.
- Circular-buffer storage with read/write pointers, so depth and width scale without shifting the data array.
- Adds an occupancy count, almost-full/almost-empty flags and a synchronous flush.
- Keeps the registered per-request status pulses (full/success/empty/success/data) the datapath already consumes.

Parameters:
DATA_W, 8, data width in bits (>=1)
DEPTH, 10, number of entries (>=2, need not be a power of 2)
AF_MARGIN, 2, almost_full asserts when count >= DEPTH-AF_MARGIN (0 <= AF_MARGIN < DEPTH)
AE_MARGIN, 2, almost_empty asserts when count <= AE_MARGIN (0 <= AE_MARGIN < DEPTH)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of FIFO contents
write_valid  input  1  write request this cycle
write_data  input  DATA_W  data to write
read_valid  input  1  read request this cycle
write_full  output  1  pulse: previous cycle's write was rejected, FIFO full
write_success  output  1  pulse: previous cycle's write accepted
read_empty  output  1  pulse: previous cycle's read was rejected, FIFO empty
read_success  output  1  pulse: previous cycle's read accepted
read_data  output  DATA_W  head entry popped by previous cycle's read; 0 otherwise
count  output  $clog2(DEPTH+1)  registered occupancy, 0..DEPTH
almost_full  output  1  decode of count register
almost_empty  output  1  decode of count register

Behaviour:
- Reset (rst_n low, async): pointers=0, count=0; write_full, write_success, read_empty, read_success=0; read_data=0; almost_empty=1, almost_full=0. Storage array is not reset.
- Requests are sampled at posedge. Status outputs are registered: valid exactly one cycle after the request, for one cycle. With no request they are 0 that cycle.
- Write accept: write_valid && (count<DEPTH || read_valid). A simultaneous read at full frees the slot, so both succeed.
- Write reject: write_valid && count==DEPTH && !read_valid gives write_full=1, write_success=0. Data is dropped and storage is unchanged.
- Read accept: read_valid && count>0. read_data takes the entry at rd_ptr as it was before the edge. read_success=1.
- Read reject: read_valid && count==0 gives read_empty=1, read_success=0, read_data=0. This holds even with a simultaneous write: the write succeeds and count becomes 1 (no bypass).
- Pointers increment modulo DEPTH and wrap from DEPTH-1 to 0 explicitly; this works for non-power-of-2 depths.
- Count update:
  - write only: +1
  - read only: -1
  - both accepted: unchanged
  - count never leaves 0..DEPTH
- almost_full and almost_empty are combinational decodes of the count register, so they update in the same cycle as count.
- Flush (sampled at posedge):
  - Pointers and count go to 0.
  - Any concurrent read/write request is discarded.
  - Next cycle all four status pulses and read_data are 0.
  - Flush has priority over all requests.
- Reset mid-operation aborts immediately; any pending status pulse is lost.
- Ordering is strict FIFO; no entry is ever duplicated or reordered across wrap-around.

Optional Feature:
- Macro FIFO_DROP_CNT_EN.
- Defined:
  - Adds output drop_cnt [15:0]: count of rejected writes (write_full events).
  - Saturates at 16'hFFFF.
  - Cleared by rst_n only; flush does not clear it.
  - Flush-discarded writes are not counted.
  - Updates on the same edge that registers write_full.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then 10 writes 0x01..0x0A, 1/cycle -> write_success=1 each following cycle; count 1..10; almost_full at count=8; 11th write 0xFF -> write_full=1, count stays 10.
- From full, 10 reads -> read_data 0x01..0x0A in order with read_success=1; 11th read -> read_empty=1, read_data=0, count=0, almost_empty=1.
- Wrap: write 7, read 7, then write 10 values 0x20..0x29 -> pointers wrap, readback 0x20..0x29 in order; also run with DEPTH=5 and DEPTH=16.
- Simultaneous read+write:
  - At full (head 0x01), write 0x55 -> both succeed, count stays 10, read_data=0x01, 0x55 read last.
  - At empty, write 0x66 -> read_empty=1, write_success=1, count=1.
- Flush at count=6 with read_valid and write_valid high -> all status 0 next cycle, count=0; subsequent read -> read_empty=1; async rst_n pulse mid-burst -> outputs 0 immediately.
- With FIFO_DROP_CNT_EN: fill, then 3 rejected writes -> drop_cnt=3; flush -> still 3; force 70000 rejects -> drop_cnt=16'hFFFF.

Source files
------------

// File: rtl/param_sync_fifo.sv
// ============================================================================
// Module      : param_sync_fifo
// Description : Parametrised single-clock circular-buffer FIFO with registered
//               per-request status pulses, occupancy count, almost-full/empty
//               flags and synchronous flush. Optional rejected-write counter
//               enabled by macro FIFO_DROP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 10,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         write_valid,
  input  logic [DATA_W-1:0]            write_data,
  input  logic                         read_valid,
  output logic                         write_full,
  output logic                         write_success,
  output logic                         read_empty,
  output logic                         read_success,
  output logic [DATA_W-1:0]            read_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty
`ifdef FIFO_DROP_CNT_EN
  ,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_PTR_W = $clog2(DEPTH);

  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_AF_LVL   = c_CNT_W'(DEPTH - AF_MARGIN);
  localparam logic [c_CNT_W-1:0] c_AE_LVL   = c_CNT_W'(AE_MARGIN);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_write_full;
  logic               r_write_success;
  logic               r_read_empty;
  logic               r_read_success;
  logic [DATA_W-1:0]  r_read_data;

  logic               w_is_full;
  logic               w_is_empty;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic               w_wr_rej;
  logic               w_rd_rej;
  logic [c_PTR_W-1:0] w_wr_ptr_nxt;
  logic [c_PTR_W-1:0] w_rd_ptr_nxt;
  logic [c_CNT_W-1:0] w_count_nxt;

  assign w_is_full  = (r_count == c_FULL_CNT);
  assign w_is_empty = (r_count == '0);

  // A read at full frees the slot the concurrent write lands in; flush wins over both.
  assign w_wr_acc = !flush && write_valid && (!w_is_full || read_valid);
  assign w_rd_acc = !flush && read_valid && !w_is_empty;
  assign w_wr_rej = !flush && write_valid && w_is_full && !read_valid;
  assign w_rd_rej = !flush && read_valid && w_is_empty;

  // Explicit wrap keeps non-power-of-2 depths correct.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_wr_acc) begin
      w_wr_ptr_nxt = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
    end
    if (w_rd_acc) begin
      w_rd_ptr_nxt = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + c_CNT_ONE;
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_nxt = r_count - c_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_full    <= 1'b0;
      r_write_success <= 1'b0;
      r_read_empty    <= 1'b0;
      r_read_success  <= 1'b0;
      r_read_data     <= '0;
    end else begin
      r_write_full    <= w_wr_rej;
      r_write_success <= w_wr_acc;
      r_read_empty    <= w_rd_rej;
      r_read_success  <= w_rd_acc;
      r_read_data     <= w_rd_acc ? r_mem[r_rd_ptr] : '0;
    end
  end

  assign write_full    = r_write_full;
  assign write_success = r_write_success;
  assign read_empty    = r_read_empty;
  assign read_success  = r_read_success;
  assign read_data     = r_read_data;
  assign count         = r_count;
  assign almost_full   = (r_count >= c_AF_LVL);
  assign almost_empty  = (r_count <= c_AE_LVL);

`ifdef FIFO_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  // Saturating; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_wr_rej && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

`default_nettype wire
